dsm_modulator_2nd: RTL and testbench

Second-order delta-sigma modulator that turns the moving-average filter's signed BW-bit output into a 1-bit pulse-density stream for the DAC output pin. It sits directly downstream of the FIR smoothing stage and updates once every `DIV` clocks. It uses two saturating integrators with 1-bit feedback, and raises a sticky overflow flag if either integrator clamps.

---
 rtl/dsm_pkg.sv | 35 +++
 rtl/dsm_tick_gen.sv | 36 +++
 rtl/dsm_modulator_2nd.sv | 88 ++++++++
 tb/tb_dsm_modulator_2nd.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsm_pkg.sv
// Shared constants and arithmetic helpers for the delta-sigma modulator and its tick generator.
// Pure functions/parameters only; no latency, no flow control.
package dsm_pkg;

  localparam int DSM_BW_DEF  = 16;
  localparam int DSM_IW_DEF  = DSM_BW_DEF + 4;
  localparam int DSM_DIV_DEF = 1;

  // Full-scale feedback magnitude for a BW-bit signed input.
  function automatic logic signed [63:0] dsm_fs(input int bw);
    return 64'sd1 <<< (bw - 1);
  endfunction

  // Clamp a sign-extended IW+1-bit result into the signed IW-bit range.
  function automatic logic signed [63:0] dsm_sat(input logic signed [63:0] val,
                                                 input int iw,
                                                 output logic clamp);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] res;
    hi    = (64'sd1 <<< (iw - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (iw - 1));
    res   = val;
    clamp = 1'b0;
    if (val > hi) begin
      res   = hi;
      clamp = 1'b1;
    end else if (val < lo) begin
      res   = lo;
      clamp = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/dsm_tick_gen.sv
// Divide-by-DIV enable strobe: combinational tick in the cycle the count reaches DIV-1.
// Dropping en_i discards the partial period; no backpressure.
module dsm_tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tick_o
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    tick_o = en_i && (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (!en_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dsm_modulator_2nd.sv
// Second-order CIFB delta-sigma modulator: signed BW-bit samples to a 1-bit density stream,
// one update per tick, dsm_o/tick_o registered (input reaches dsm_o one tick later); no backpressure.
module dsm_modulator_2nd
  import dsm_pkg::*;
#(
  parameter int BW  = DSM_BW_DEF,
  parameter int IW  = DSM_IW_DEF,
  parameter int DIV = DSM_DIV_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic signed [BW-1:0] dsm_i,
  input  logic                 clr_ovf_i,
  output logic                 dsm_o,
  output logic                 tick_o,
  output logic                 ovf_o
);

  localparam logic signed [IW-1:0] FB_MAG = IW'(dsm_fs(BW));

  logic                 tick;
  logic signed [IW-1:0] fb;
  logic signed [IW-1:0] i1_q, i1_d;
  logic signed [IW-1:0] i2_q, i2_d;
  logic                 dsm_q, dsm_d;
  logic                 tick_q;
  logic                 ovf_q, ovf_d;
  logic signed [IW:0]   sum1, sum2;
  logic signed [63:0]   sat1, sat2;
  logic                 clamp1, clamp2;

  dsm_tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (en_i),
    .tick_o(tick)
  );

  assign fb = dsm_q ? FB_MAG : -FB_MAG;

  always_comb begin
    // One guard bit is enough: |i1| + |dsm_i| + FS never exceeds 2^IW when IW >= BW+2.
    sum1 = {i1_q[IW-1], i1_q} + {{(IW + 1 - BW){dsm_i[BW-1]}}, dsm_i} - {fb[IW-1], fb};
    sum2 = {i2_q[IW-1], i2_q} + {i1_q[IW-1], i1_q} - {fb[IW-1], fb};
    sat1 = dsm_sat({{(63 - IW){sum1[IW]}}, sum1}, IW, clamp1);
    sat2 = dsm_sat({{(63 - IW){sum2[IW]}}, sum2}, IW, clamp2);

    i1_d  = i1_q;
    i2_d  = i2_q;
    dsm_d = dsm_q;
    ovf_d = ovf_q;
    if (tick) begin
      i1_d  = IW'(sat1);
      i2_d  = IW'(sat2);
      dsm_d = !i2_d[IW-1];
    end
    if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end
    if (tick && (clamp1 || clamp2)) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      i1_q   <= '0;
      i2_q   <= '0;
      dsm_q  <= 1'b0;
      tick_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      i1_q   <= i1_d;
      i2_q   <= i2_d;
      dsm_q  <= dsm_d;
      tick_q <= tick;
      ovf_q  <= ovf_d;
    end
  end

  assign dsm_o  = dsm_q;
  assign tick_o = tick_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_dsm_modulator_2nd.sv
// Three modulator instances (DIV=1, DIV=4, narrow IW) against a per-tick arithmetic reference.
module tb_dsm_modulator_2nd;

  localparam longint FS    = 32768;
  localparam int     IW_A  = 20;
  localparam int     IW_N  = 18;
  localparam int     DIV_B = 4;

  typedef struct {
    longint i1;
    longint i2;
    bit     q;
    bit     ovf;
    bit     tk;
    int     run;
    bit     clamp;
  } mdl_t;

  logic                clk;
  logic                rst_n;
  logic [2:0]          en;
  logic [2:0]          clr;
  logic signed [15:0]  din [3];
  logic [2:0]          q_o;
  logic [2:0]          tk_o;
  logic [2:0]          ov_o;

  mdl_t m [3];
  int   n_checks;
  int   n_fail;

  dsm_modulator_2nd #(.BW(16), .IW(IW_A), .DIV(1)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en[0]), .dsm_i(din[0]), .clr_ovf_i(clr[0]),
    .dsm_o(q_o[0]), .tick_o(tk_o[0]), .ovf_o(ov_o[0]));

  dsm_modulator_2nd #(.BW(16), .IW(IW_A), .DIV(DIV_B)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en[1]), .dsm_i(din[1]), .clr_ovf_i(clr[1]),
    .dsm_o(q_o[1]), .tick_o(tk_o[1]), .ovf_o(ov_o[1]));

  dsm_modulator_2nd #(.BW(16), .IW(IW_N), .DIV(1)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en[2]), .dsm_i(din[2]), .clr_ovf_i(clr[2]),
    .dsm_o(q_o[2]), .tick_o(tk_o[2]), .ovf_o(ov_o[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int div_of(input int g);
    return (g == 1) ? DIV_B : 1;
  endfunction

  function automatic int iw_of(input int g);
    return (g == 2) ? IW_N : IW_A;
  endfunction

  function automatic mdl_t mzero();
    mdl_t z;
    z = '{0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    return z;
  endfunction

  // One clock of the reference: a tick fires on the DIV-th consecutive enabled cycle.
  function automatic mdl_t mstep(input mdl_t s, input bit e, input longint x, input bit c,
                                 input int div, input int iw);
    mdl_t   n;
    longint hi, lo, fb, a, b;
    bit     fire;
    n       = s;
    hi      = (longint'(1) << (iw - 1)) - 1;
    lo      = -(longint'(1) << (iw - 1));
    n.clamp = 1'b0;
    fire    = e && (s.run + 1 == div);
    n.run   = (e && !fire) ? s.run + 1 : 0;
    n.tk    = fire;
    if (fire) begin
      fb = s.q ? FS : -FS;
      a  = s.i1 + x - fb;
      b  = s.i2 + s.i1 - fb;
      if (a > hi) begin a = hi; n.clamp = 1'b1; end
      else if (a < lo) begin a = lo; n.clamp = 1'b1; end
      if (b > hi) begin b = hi; n.clamp = 1'b1; end
      else if (b < lo) begin b = lo; n.clamp = 1'b1; end
      n.i1 = a;
      n.i2 = b;
      n.q  = (b >= 0);
    end
    if (c) n.ovf = 1'b0;
    if (n.clamp) n.ovf = 1'b1;
    return n;
  endfunction

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock, update all reference models, compare every output.
  task automatic step();
    @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      if (!rst_n) m[g] = mzero();
      else m[g] = mstep(m[g], en[g], longint'(din[g]), clr[g], div_of(g), iw_of(g));
      check_eq($sformatf("dsm%0d", g), q_o[g], m[g].q);
      check_eq($sformatf("tick%0d", g), tk_o[g], m[g].tk);
      check_eq($sformatf("ovf%0d", g), ov_o[g], m[g].ovf);
    end
  endtask

  task automatic run_const(input int g, input longint x, input int n, output int ones);
    ones = 0;
    din[g] = 16'(x);
    for (int k = 0; k < n; k++) begin
      step();
      if (tk_o[g]) ones += int'(q_o[g]);
    end
  endtask

  task automatic check_density(input string tag, input int ones, input int target, input int tol);
    int d;
    d = ones - target;
    check_eq(tag, (d >= -tol && d <= tol) ? target : ones, target);
  endtask

  function automatic logic [15:0] rnd_half();
    int t;
    t = int'($urandom_range(32768)) - 16384;
    return 16'(t);
  endfunction

  initial begin
    int   ones;
    int   cyc;
    int   last;
    int   wait_n;
    bit   seen;
    bit   found;
    bit   qsave;
    bit   qprev;
    mdl_t p;

    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    en       = '0;
    clr      = '0;
    for (int g = 0; g < 3; g++) begin
      din[g] = 16'($urandom);
      m[g]   = mzero();
    end

    // Reset held for three edges with random input.
    for (int k = 0; k < 3; k++) begin
      for (int g = 0; g < 3; g++) din[g] = 16'($urandom);
      step();
    end
    check_eq("rst_dsm", q_o[0], 0);
    check_eq("rst_tick", tk_o[0], 0);
    check_eq("rst_ovf", ov_o[0], 0);
    en[0] = 1'b1;
    din[0] = 16'd0;
    #2 rst_n = 1'b1;
    step();
    check_eq("rel_tick_first", tk_o[0], 1);

    // Zero input: ones density around 50%.
    run_const(0, 0, 1023, ones);
    ones += int'(m[0].q);
    check_density("zero_ones", ones, 512, 2);
    check_eq("zero_ovf", ov_o[0], 0);

    // Half scale both polarities.
    run_const(0, 16384, 4096, ones);
    check_density("half_pos_ones", ones, 3072, 4);
    run_const(0, -16384, 4096, ones);
    check_density("half_neg_ones", ones, 1024, 4);
    check_eq("half_ovf", ov_o[0], 0);

    // Asynchronous reset between edges during a half-scale run.
    run_const(0, 16384, 150, ones);
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      check_eq($sformatf("arst_dsm%0d", g), q_o[g], 0);
      check_eq($sformatf("arst_tick%0d", g), tk_o[g], 0);
      check_eq($sformatf("arst_ovf%0d", g), ov_o[g], 0);
      m[g] = mzero();
    end
    #2 rst_n = 1'b1;
    run_const(0, 16384, 300, ones);

    // Random in-range input with occasional flag clears.
    for (int k = 0; k < 2000; k++) begin
      din[0] = rnd_half();
      clr[0] = ($urandom_range(15) == 0);
      step();
    end
    clr[0] = 1'b0;
    en[0]  = 1'b0;

    // Divider: ticks every 4th cycle, dsm_o only moves on ticks.
    en[1] = 1'b1;
    cyc   = 0;
    last  = 0;
    qprev = q_o[1];
    for (int k = 0; k < 40; k++) begin
      din[1] = rnd_half();
      step();
      cyc++;
      check_eq("div4_hold", (q_o[1] != qprev && !tk_o[1]) ? 1 : 0, 0);
      qprev = q_o[1];
      if (tk_o[1]) begin
        check_eq("div4_period", cyc - last, DIV_B);
        last = cyc;
      end
    end
    // Align to just after a tick, advance two counts, then drop enable for two cycles.
    wait_n = 0;
    while (!tk_o[1] && wait_n < 8) begin
      din[1] = rnd_half();
      step();
      wait_n++;
    end
    check_eq("div4_align", tk_o[1], 1);
    for (int k = 0; k < 2; k++) begin
      din[1] = rnd_half();
      step();
    end
    qsave = q_o[1];
    en[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      din[1] = rnd_half();
      step();
    end
    check_eq("div4_off_state", q_o[1], qsave);
    en[1]  = 1'b1;
    wait_n = 0;
    found  = 1'b0;
    while (!found && wait_n < 12) begin
      din[1] = rnd_half();
      step();
      wait_n++;
      found = tk_o[1];
    end
    check_eq("div4_restart", found ? wait_n : -1, DIV_B);

    // Random enable pattern with full-range input.
    for (int k = 0; k < 1500; k++) begin
      en[1]  = ($urandom_range(3) != 0);
      din[1] = 16'($urandom);
      clr[1] = ($urandom_range(31) == 0);
      step();
    end
    en[1]  = 1'b0;
    clr[1] = 1'b0;

    // Narrow integrators driven at near full scale.
    en[2] = 1'b1;
    seen  = 1'b0;
    din[2] = 16'sd32767;
    for (int k = 0; k < 4096; k++) begin
      step();
      if (seen) check_eq("ovf_sticky", ov_o[2], 1);
      seen = seen | ov_o[2];
    end
    check_eq("ovf_set", ov_o[2], 1);
    en[2]  = 1'b0;
    clr[2] = 1'b1;
    step();
    clr[2] = 1'b0;
    check_eq("ovf_clr", ov_o[2], 0);
    en[2] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 64 && !found; k++) begin
      p      = mstep(m[2], 1'b1, 32767, 1'b1, div_of(2), iw_of(2));
      clr[2] = p.clamp;
      step();
      if (p.clamp) begin
        check_eq("ovf_set_wins", ov_o[2], 1);
        found = 1'b1;
      end
    end
    clr[2] = 1'b0;
    check_eq("ovf_clamp_found", found, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
